// File: rtl/sram_ctrl.sv
// sram_ctrl: memory-side responder for the MEM stage. Each 32-bit word
// access is split into two 16-bit accesses on an asynchronous SRAM (low
// half-word first), each lasting WAIT_CYCLES clocks. ready stays low while
// an access is in flight so the pipeline freezes.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   wr_en, rd_en         store / load request (store wins if both high)
//   address, wdata       byte address and store data (latched in IDLE)
//   rdata                registered load result, held until next load
//   ready                high when no access is pending
//   SRAM_DQ              bidirectional half-word data bus
//   SRAM_ADDR, SRAM_WE_N registered SRAM address and write strobe
//   SRAM_CE_N/OE_N/UB_N/LB_N  permanently enabled (0)
module sram_ctrl #(
   parameter int WORD_WIDTH  = 32,
   parameter int SRAM_ADDR_W = 18,
   parameter int SRAM_DATA_W = 16,
   parameter int WAIT_CYCLES = 2,
   parameter int MEM_BASE    = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [WORD_WIDTH-1:0]  address,
   input  logic [WORD_WIDTH-1:0]  wdata,
   output logic [WORD_WIDTH-1:0]  rdata,
   output logic                   ready,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
   localparam int IDX_W = SRAM_ADDR_W - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   op_wr_q, op_wr_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [WORD_WIDTH-1:0]  wdata_q, wdata_d;
   logic [WORD_WIDTH-1:0]  rdata_q, rdata_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic                   we_n_q, we_n_d;

   logic                   req;
   logic                   last;
   logic [CNT_W-1:0]       cnt_nxt;
   logic [WORD_WIDTH-1:0]  offset;
   logic [IDX_W-1:0]       idx_in;
   logic                   dq_oe;
   logic [SRAM_DATA_W-1:0] dq_out;
   logic                   unused_offset_bits;

   assign req     = rd_en | wr_en;
   assign last    = (cnt_q == CNT_LAST);
   assign cnt_nxt = cnt_q + CNT_ONE;

   // Word index relative to the SRAM window; byte lane bits are dropped.
   assign offset = address - WORD_WIDTH'(MEM_BASE);
   assign idx_in = offset[IDX_W+1:2];
   assign unused_offset_bits = &{1'b0, offset[1:0], offset[WORD_WIDTH-1:IDX_W+2]};

   // State register and latched request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         we_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         we_n_q  <= we_n_d;
      end
   end

   // Next-state: sequencing and the wait counter (1..WAIT_CYCLES per half).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_LOW;
               cnt_d   = CNT_ONE;
               op_wr_d = wr_en;
               idx_d   = idx_in;
               wdata_d = wdata;
            end
         end
         S_LOW: begin
            if (last) begin
               state_d = S_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = cnt_nxt;
            end
         end
         S_HIGH: begin
            if (last) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_nxt;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs. SRAM_ADDR/WE_N are registered, so their next values are set up
   // one cycle ahead: WE_N drops on the first cycle of a write half and rises
   // on its last cycle, keeping the address stable while WE_N is low.
   always_comb begin
      ready   = 1'b0;
      dq_oe   = 1'b0;
      dq_out  = wdata_q[SRAM_DATA_W-1:0];
      addr_d  = addr_q;
      we_n_d  = 1'b1;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            ready = ~req;
            if (req) begin
               addr_d = {idx_in, 1'b0};
               we_n_d = ~wr_en;
            end
         end
         S_LOW: begin
            dq_oe  = op_wr_q;
            dq_out = wdata_q[SRAM_DATA_W-1:0];
            if (last) begin
               addr_d = {idx_q, 1'b1};
               we_n_d = ~op_wr_q;
               if (!op_wr_q) rdata_d[SRAM_DATA_W-1:0] = SRAM_DQ;
            end else begin
               we_n_d = ~op_wr_q | (cnt_nxt == CNT_LAST);
            end
         end
         S_HIGH: begin
            dq_oe  = op_wr_q;
            dq_out = wdata_q[2*SRAM_DATA_W-1:SRAM_DATA_W];
            if (last) begin
               if (!op_wr_q) rdata_d[2*SRAM_DATA_W-1:SRAM_DATA_W] = SRAM_DQ;
            end else begin
               we_n_d = ~op_wr_q | (cnt_nxt == CNT_LAST);
            end
         end
         S_DONE: ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // DQ enable comes straight from the state register so an asynchronous
   // reset releases the bus in the same cycle.
   assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};
   assign SRAM_ADDR = addr_q;
   assign SRAM_WE_N = we_n_q;
   assign rdata     = rdata_q;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM model on the bus, a driver issuing
// directed requests (pushing the expected response into a queue), and a
// monitor that pops and compares each completed access.
module tb_sram_ctrl;
   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [31:0] address, wdata;
   logic [31:0] rdata;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;

   always #5 clk = ~clk;

   sram_ctrl dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
   );

   // SRAM model: drives the bus on reads (bench-enabled) or with a probe
   // pattern used to show the controller has released DQ.
   logic [15:0] mem [64];
   logic        sram_out_en = 1'b0;
   logic        probe = 1'b0;
   logic [15:0] dq_drv;
   assign dq_drv  = probe ? 16'h5A3C : mem[SRAM_ADDR[5:0]];
   assign sram_dq = (probe || (sram_out_en && SRAM_WE_N)) ? dq_drv : 16'bz;

   // Write captured while WE_N is low, committed when WE_N returns high;
   // a reset in between abandons it.
   logic        pend = 1'b0;
   logic [5:0]  pa;
   logic [15:0] pd;
   always @(negedge clk) begin
      if (rst) pend = 1'b0;
      else if (!SRAM_WE_N) begin pend = 1'b1; pa = SRAM_ADDR[5:0]; pd = sram_dq; end
      else if (pend) begin mem[pa] = pd; pend = 1'b0; end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      int          we_lo;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   // Monitor: counts ready-low cycles and WE_N-low cycles of each access and
   // compares at the cycle ready returns high.
   bit busy = 1'b0;
   int lo_cnt, we_cnt;
   always @(negedge clk) begin
      if (rst) busy = 1'b0;
      else if (busy && ready) begin
         busy = 1'b0;
         if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, "_rdata"}, rdata, e.rdata);
            chk({e.name, "_busy_cycles"}, 32'(lo_cnt), 32'(2*W+1));
            chk({e.name, "_we_low_cycles"}, 32'(we_cnt), 32'(e.we_lo));
         end
      end else if (busy) begin
         lo_cnt++;
         if (!SRAM_WE_N) we_cnt++;
      end else if ((rd_en || wr_en) && !ready) begin
         busy = 1'b1; lo_cnt = 1; we_cnt = 0;
      end
   end

   // Called one step after a rising edge in an IDLE cycle; returns one step
   // after the rising edge that ends DONE, i.e. in the next IDLE cycle.
   task automatic do_req(input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd);
      exp_t e;
      int n;
      e.rdata = exp_rd; e.we_lo = wr ? 2*(W-1) : 0; e.name = name;
      exp_q.push_back(e);
      rd_en = rd; wr_en = wr; address = a; wdata = d; sram_out_en = !wr;
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      n = 0;
      while (!ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk({name, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
      #23 rst = 1'b0;
      @(negedge clk);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_we_n", 32'(SRAM_WE_N), 32'd1);
      chk("reset_addr", 32'(SRAM_ADDR), 32'd0);
      chk("idle_ready", 32'(ready), 32'd1);
      probe = 1'b1; #1;
      chk("idle_dq_released", 32'(sram_dq), 32'h5A3C);
      probe = 1'b0;
      @(posedge clk); #1;

      do_req("wr1032", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0);
      chk("mem4", 32'(mem[4]), 32'hBEEF);
      chk("mem5", 32'(mem[5]), 32'hDEAD);
      do_req("rd1032", 1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF);
      do_req("wr1036", 1'b0, 1'b1, 32'd1036, 32'h11112222, 32'hDEADBEEF);
      chk("mem6", 32'(mem[6]), 32'h2222);
      chk("mem7", 32'(mem[7]), 32'h1111);

      // Back-to-back: the read is presented in the IDLE cycle right after DONE.
      do_req("wr1024", 1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF);
      do_req("rd1024_b2b", 1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678);

      // Reset in the first HIGH cycle of a write.
      sram_out_en = 1'b0;
      wr_en = 1'b1; address = 32'd1024; wdata = 32'hCAFEF00D;
      @(posedge clk); #1; wr_en = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("midwr_we_low", 32'(SRAM_WE_N), 32'd0);
      chk("midwr_addr_high", 32'(SRAM_ADDR), 32'd1);
      @(negedge clk); #1;
      rst = 1'b1; probe = 1'b1; #1;
      chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
      chk("rst_dq_released", 32'(sram_dq), 32'h5A3C);
      chk("rst_ready_idle", 32'(ready), 32'd1);
      chk("rst_rdata", rdata, 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0; probe = 1'b0;
      chk("rst_mem1_kept", 32'(mem[1]), 32'h1234);
      @(posedge clk); #1;

      do_req("rd1032_after_rst", 1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF);
      do_req("both_en", 1'b1, 1'b1, 32'd1040, 32'hA5A5A5A5, 32'hDEADBEEF);
      chk("mem8", 32'(mem[8]), 32'hA5A5);
      chk("mem9", 32'(mem[9]), 32'hA5A5);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
